conv_layer: RTL and testbench
=============================

# conv_layer

Single-output convolution neuron for the convolutional neural-core datapath. Each clock it takes one 6-element receptive-field window of signed 6-bit activations and a matching 6-element signed 6-bit kernel. It forms their dot product through a two-stage pipeline and emits a 1-bit binarized activation (sum strictly greater than a threshold). The upstream window generator supplies one output position per cycle; downstream logic consumes the 1-bit feature-map stream.

## Interface
- THRESHOLD, default 0: signed 14-bit comparison threshold; data_out = 1 iff dot product > THRESHOLD.
- clk  input  1  rising-edge clock; sole clock domain.
- rst_n  input  1  reset, asynchronous and active-high despite the name. 1 = reset asserted; it clears all state immediately.
- data_in  input  [5:0][5:0] (36)  six signed two's-complement 6-bit activations; element i = data_in[i] = bits [6i+5:6i].
- kernel  input  [5:0][5:0] (36)  six signed two's-complement 6-bit weights; element i pairs with data_in[i].
- data_out  output  1  registered binarized activation.

## Operation
- Stage 0, input capture: on each rising edge, register data_in and kernel into a_r and w_r. Set valid bit v0 = 1.
- Stage 1, multiply: p[i] = a_r[i] * w_r[i].
  - Signed 6x6 multiply gives a 12-bit signed product, range -992..1024.
  - Register all six products; v1 <= v0.
- Stage 2, accumulate and activate: s = sum of p[0..5].
  - Sign-extend every product to 14 bits before adding. Range is -5952..6144, so no overflow or saturation is possible.
  - Compare signed: data_out <= v1 & (s > THRESHOLD).
  - The comparison is strict, so s == THRESHOLD gives 0.
- Adder-tree structure is free. It must be combinational within stage 2, with no extra register.
- No enable or handshake: a new window is accepted every cycle unconditionally, fully pipelined, throughput 1 per cycle.
- Reset (rst_n = 1):
  - asynchronously clears a_r, w_r, the product registers, v0, v1 and data_out to 0;
  - data_out reads 0 for as long as reset is held, regardless of inputs.
- Valid bits v0/v1 gate data_out to 0 until the pipeline refills after reset. This holds even when THRESHOLD is negative, where the zeroed registers would otherwise compare true.

## Timing
- Latency: inputs stable before rising edge k produce data_out valid after rising edge k+2. That is 2 cycles, registered output.
- Reset release: the first edge after rst_n falls is edge 1.
  - data_out is 0 after edges 1 and 2 (gated by v1).
  - The first real result appears after edge 3 and reflects the inputs sampled at edge 1.
- Reset mid-stream: data_out drops to 0 asynchronously, without waiting for a clock edge. All in-flight windows are discarded and never emitted.
- Input changes between edges have no effect. Only values at the rising edge are sampled.
- Back-to-back distinct windows each cycle give one distinct output per cycle, in order, with no bubbles.

## Test plan
- Reset: hold rst_n = 1 with all activations 1 and weights 1 -> data_out = 0 throughout. Release rst_n -> data_out stays 0 after edges 1 and 2 and becomes 1 after edge 3.
- Basic sign: activations all 1, weights all 1 -> s = 6 -> data_out = 1. Weights all -1 (6'h3F) -> s = -6 -> data_out = 0. Each result appears 2 edges after sampling.
- Extremes: activations all -32 (6'h20) and weights all -32 -> s = 6144 -> 1. Activations all -32 and weights all 31 (6'h1F) -> s = -5952 -> 0. These check no overflow occurs.
- Strict boundary: activations all 1, weights {1,1,1,-1,-1,-1} -> s = 0 -> data_out = 0. Rerun with THRESHOLD = -1 -> data_out = 1.
- Streaming: alternate windows s = +6 and s = -6 on consecutive edges for 10 cycles -> data_out toggles 1,0,1,0… with a 2-cycle lag, and no missing or duplicated results.
- Reset mid-stream: while data_out = 1, assert rst_n = 1 between clock edges -> data_out goes to 0 before the next edge. After release, data_out stays 0 for 2 edges even though s = +6 inputs are present.

Source files
------------

// File: rtl/conv_layer.sv
// Two-stage pipelined 6-element signed dot product with a binarized threshold output.
// Input capture, then multiply, then adder tree and strict compare feeding data_out.
module conv_layer #(
  parameter logic signed [13:0] THRESHOLD = 14'sd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0][5:0] data_in,
  input  logic [5:0][5:0] kernel,
  output logic            data_out
);

  localparam int unsigned N  = 6;
  localparam int unsigned AW = 6;
  localparam int unsigned PW = 12;
  localparam int unsigned SW = 14;

  logic [N-1:0][AW-1:0] a_q, w_q;
  logic [N-1:0][PW-1:0] p_q, p_d;
  logic                 v0_q, v1_q;
  logic                 data_out_d;
  logic signed [SW-1:0] sum_c;

  // Operands are sign-extended to the product width so the multiply is exact.
  always_comb begin
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] we;
    p_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      ae      = {{(PW-AW){a_q[i][AW-1]}}, a_q[i]};
      we      = {{(PW-AW){w_q[i][AW-1]}}, w_q[i]};
      p_d[i]  = PW'(ae * we);
    end
  end

  // The 14-bit sum covers -5952..6144, so neither overflow nor saturation occurs.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum_c = sum_c + SW'($signed({{(SW-PW){p_q[i][PW-1]}}, p_q[i]}));
    end
    data_out_d = v1_q & (sum_c > THRESHOLD);
  end

  // rst_n is active-high: asserting it clears every stage immediately.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q      <= '0;
      w_q      <= '0;
      p_q      <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      data_out <= 1'b0;
    end else begin
      a_q      <= data_in;
      w_q      <= kernel;
      p_q      <= p_d;
      v0_q     <= 1'b1;
      v1_q     <= v0_q;
      data_out <= data_out_d;
    end
  end

endmodule

// File: tb/tb_conv_layer.sv
// Self-checking bench for conv_layer: hand vectors, reset corners and random windows
// compared against a queue model of sampled dot products.
module tb_conv_layer;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [5:0][5:0] din, kin;
  logic            q0, q1;

  always #5 clk = ~clk;

  conv_layer #(.THRESHOLD(14'sd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .kernel(kin), .data_out(q0));
  conv_layer #(.THRESHOLD(-14'sd1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .kernel(kin), .data_out(q1));

  typedef struct {
    logic [5:0][5:0] a;
    logic [5:0][5:0] w;
    logic            e0;
    logic            e1;
  } vec_t;

  vec_t tbl[7];
  int   hist[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [5:0][5:0] fill(input logic [5:0] v);
    logic [5:0][5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v;
    return r;
  endfunction

  function automatic logic [5:0][5:0] mk(input logic [5:0] e0, e1, e2, e3, e4, e5);
    logic [5:0][5:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3; r[4] = e4; r[5] = e5;
    return r;
  endfunction

  function automatic int dot(input logic [5:0][5:0] a, input logic [5:0][5:0] w);
    int s = 0;
    for (int i = 0; i < 6; i++) s += int'($signed(a[i])) * int'($signed(w[i]));
    return s;
  endfunction

  // Output after an edge reflects the window sampled two edges earlier, if one exists since reset.
  function automatic logic expv(input int thr);
    int n = hist.size();
    if (n < 3) return 1'b0;
    return (hist[n-3] > thr) ? 1'b1 : 1'b0;
  endfunction

  task automatic chk(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) hist.push_back(dot(din, kin));
    #1;
    chk("model_thr0", q0, expv(0));
    chk("model_thrm1", q1, expv(-1));
  endtask

  task automatic assert_reset();
    rst_n = 1'b1;
    hist.delete();
    #1;
    chk("async_rst_thr0", q0, 1'b0);
    chk("async_rst_thrm1", q1, 1'b0);
  endtask

  initial begin
    tbl[0] = '{fill(6'h01), fill(6'h01), 1'b1, 1'b1};                  //  6
    tbl[1] = '{fill(6'h01), fill(6'h3F), 1'b0, 1'b0};                  // -6
    tbl[2] = '{fill(6'h20), fill(6'h20), 1'b1, 1'b1};                  //  6144
    tbl[3] = '{fill(6'h20), fill(6'h1F), 1'b0, 1'b0};                  // -5952
    tbl[4] = '{fill(6'h01), mk(6'h01, 6'h01, 6'h01, 6'h3F, 6'h3F, 6'h3F), 1'b0, 1'b1}; // 0
    tbl[5] = '{fill(6'h00), fill(6'h00), 1'b0, 1'b1};                  //  0
    tbl[6] = '{fill(6'h01), mk(6'h01, 6'h01, 6'h3F, 6'h3F, 6'h3F, 6'h00), 1'b0, 1'b0}; // -1

    // Reset held with s = +6 inputs, then release: 0, 0, 1.
    din = fill(6'h01);
    kin = fill(6'h01);
    rst_n = 1'b1;
    #1;
    chk("rst_hold0", q0, 1'b0);
    repeat (3) step();
    #3 rst_n = 1'b0;
    step(); chk("rel_e1", q0, 1'b0); chk("rel_e1_m1", q1, 1'b0);
    step(); chk("rel_e2", q0, 1'b0); chk("rel_e2_m1", q1, 1'b0);
    step(); chk("rel_e3", q0, 1'b1); chk("rel_e3_m1", q1, 1'b1);

    // Table vectors, each held until it reaches the output.
    for (int i = 0; i < 7; i++) begin
      din = tbl[i].a;
      kin = tbl[i].w;
      repeat (3) step();
      chk($sformatf("vec%0d_thr0", i), q0, tbl[i].e0);
      chk($sformatf("vec%0d_thrm1", i), q1, tbl[i].e1);
    end

    // Streaming: alternating +6 / -6 windows every edge, 2-edge lag.
    for (int j = 0; j < 12; j++) begin
      din = fill(6'h01);
      kin = (j % 2 == 0) ? fill(6'h01) : fill(6'h3F);
      step();
      if (j >= 2) chk($sformatf("stream%0d", j), q0, ((j - 2) % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Mid-stream reset while data_out is 1.
    din = fill(6'h01);
    kin = fill(6'h01);
    repeat (3) step();
    chk("pre_rst_high", q0, 1'b1);
    #2 assert_reset();
    step();
    #3 rst_n = 1'b0;
    step(); chk("mid_rel_e1", q0, 1'b0);
    step(); chk("mid_rel_e2", q0, 1'b0);
    step(); chk("mid_rel_e3", q0, 1'b1);

    // Random windows with mid-cycle glitches that must not be sampled.
    for (int j = 0; j < 300; j++) begin
      din = 36'($urandom()) ^ {36'($urandom()) << 4};
      kin = 36'($urandom()) ^ {36'($urandom()) << 4};
      #2;
      if ($urandom_range(0, 3) == 0) begin
        din = fill(6'h20);
        kin = fill(6'h20);
        #2;
        din = 36'($urandom());
        kin = fill(6'(int'($urandom_range(0, 1)) * 2 - 1));
      end
      if ($urandom_range(0, 49) == 0) begin
        assert_reset();
        #2 rst_n = 1'b0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
